// File: rtl/uart_pkg.sv
// Shared UART package: arbiter FSM encoding, requester-count limits,
// the default data width shared with the uart top, and an index-width helper.
package uart_pkg;

    // Arbiter FSM encoding
    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_t;

    // Legal range for the number of arbiter requesters
    localparam int ARB_NREQ_MIN = 2;
    localparam int ARB_NREQ_MAX = 8;

    // Data width shared with the uart core
    localparam int UART_DBITS = 8;

    // Width of an index into n items (at least one bit)
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: grants the first set request strictly
// above ptr, wrapping to the lowest set request when none lies above it.
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PW   = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   idx,
    output logic            any
);

    localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

    // Mask of requester positions holding index bit b set, used to encode idx
    function automatic logic [NREQ-1:0] bit_sel(input int b);
        logic [NREQ-1:0] r;
        r = '0;
        for (int i = 0; i < NREQ; i++) begin
            r[i] = 1'((i >> b) & 1);
        end
        return r;
    endfunction

    logic [NREQ-1:0] above_ptr;
    logic [NREQ-1:0] masked;
    logic [NREQ-1:0] pick_src;
    logic [NREQ-1:0] lowest;

    // Positions strictly after the pointer get first chance
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_mask
            assign above_ptr[gi] = (PW'(gi) > ptr);
        end
    endgenerate

    assign masked   = req & above_ptr;
    assign pick_src = (|masked) ? masked : req;
    // Isolate the lowest set bit of the chosen request set
    assign lowest   = pick_src & (~pick_src + ONE);

    assign gnt = lowest;
    assign any = |req;

    // One-hot to binary encoding of the winner
    generate
        for (genvar gi = 0; gi < PW; gi++) begin : g_idx
            assign idx[gi] = |(lowest & bit_sel(gi));
        end
    endgenerate

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locking arbiter sharing the UART TX write port among
// NREQ requesters. A grant is held until the owner writes a byte flagged last.
// Optional feature macro: UART_ARB_TIMEOUT_EN -- forces release of a locked
// packet whose owner stays idle for TIMEOUT cycles and pulses o_timeout.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int DBITS   = UART_DBITS,
    parameter int TIMEOUT = 1024
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [NREQ-1:0]       i_req_valid,
    input  logic [NREQ*DBITS-1:0] i_req_data,
    input  logic [NREQ-1:0]       i_req_last,
    output logic [NREQ-1:0]       o_req_ready,
    output logic                  o_wr_uart,
    output logic [DBITS-1:0]      o_wr_data,
    input  logic                  i_tx_full,
    output logic [NREQ-1:0]       o_grant,
    output logic                  o_busy,
    output logic                  o_timeout
);

    localparam int PW = idx_width(NREQ);

    generate
        if (NREQ < ARB_NREQ_MIN || NREQ > ARB_NREQ_MAX) begin : g_bad_nreq
            $error("uart_tx_arbiter: NREQ out of range");
        end
        if (TIMEOUT < 2) begin : g_bad_timeout
            $error("uart_tx_arbiter: TIMEOUT must be at least 2");
        end
    endgenerate

    arb_state_t      state_reg, state_next;
    logic [NREQ-1:0] grant_reg, grant_next;
    logic [PW-1:0]   gidx_reg,  gidx_next;
    logic [PW-1:0]   ptr_reg,   ptr_next;

    logic [NREQ-1:0] pick_gnt;
    logic [PW-1:0]   pick_idx;
    logic            pick_any;

    logic            valid_g;
    logic            last_g;
    logic            xfer;

    uart_rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req (i_req_valid),
        .ptr (ptr_reg),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Owner's handshake signals selected through the one-hot grant
    assign valid_g = |(i_req_valid & grant_reg);
    assign last_g  = |(i_req_last & grant_reg);
    assign o_busy  = (state_reg == ARB_LOCK);
    assign xfer    = o_busy & valid_g & ~i_tx_full;

    assign o_grant     = grant_reg;
    assign o_req_ready = (o_busy && !i_tx_full) ? grant_reg : '0;
    assign o_wr_uart   = xfer;

    // AND-OR data mux; yields zero whenever nothing is granted
    always_comb begin
        o_wr_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            o_wr_data = o_wr_data | ({DBITS{grant_reg[i]}} & i_req_data[i*DBITS +: DBITS]);
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TW = idx_width(TIMEOUT);

    logic [TW-1:0] tcnt_reg, tcnt_next;
    logic          timeout_pulse;

    assign o_timeout = timeout_pulse;
`else
    assign o_timeout = 1'b0;
`endif

    // State, grant, pointer (and idle counter) registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= ARB_IDLE;
            grant_reg <= '0;
            gidx_reg  <= '0;
            ptr_reg   <= PW'(NREQ - 1);
`ifdef UART_ARB_TIMEOUT_EN
            tcnt_reg  <= '0;
`endif
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            gidx_reg  <= gidx_next;
            ptr_reg   <= ptr_next;
`ifdef UART_ARB_TIMEOUT_EN
            tcnt_reg  <= tcnt_next;
`endif
        end
    end

    // Next-state logic: arbitrate in IDLE, hold the grant in LOCK until last byte
    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        gidx_next  = gidx_reg;
        ptr_next   = ptr_reg;
`ifdef UART_ARB_TIMEOUT_EN
        tcnt_next     = tcnt_reg;
        timeout_pulse = 1'b0;
`endif
        case (state_reg)
            ARB_IDLE: begin
                if (pick_any) begin
                    state_next = ARB_LOCK;
                    grant_next = pick_gnt;
                    gidx_next  = pick_idx;
`ifdef UART_ARB_TIMEOUT_EN
                    tcnt_next  = '0;
`endif
                end
            end
            ARB_LOCK: begin
                if (xfer) begin
`ifdef UART_ARB_TIMEOUT_EN
                    tcnt_next = '0;
`endif
                    if (last_g) begin
                        state_next = ARB_IDLE;
                        grant_next = '0;
                        ptr_next   = gidx_reg;
                    end
                end
`ifdef UART_ARB_TIMEOUT_EN
                // Only cycles where the owner has nothing to send count as idle;
                // full-FIFO stalls with valid held high leave the counter alone.
                else if (!valid_g) begin
                    if (tcnt_reg == TW'(TIMEOUT - 1)) begin
                        timeout_pulse = 1'b1;
                        state_next    = ARB_IDLE;
                        grant_next    = '0;
                        ptr_next      = gidx_reg;
                        tcnt_next     = '0;
                    end else begin
                        tcnt_next = tcnt_reg + TW'(1);
                    end
                end
`endif
            end
            default: begin
                state_next = ARB_IDLE;
                grant_next = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed testbench for uart_tx_arbiter (NREQ=4, DBITS=8, TIMEOUT=16).
module tb_uart_tx_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  o_req_ready;
    logic        o_wr_uart;
    logic [7:0]  o_wr_data;
    logic        tx_full;
    logic [3:0]  o_grant;
    logic        o_busy;
    logic        o_timeout;

    int pass_cnt = 0;
    int total_cnt = 0;

    uart_tx_arbiter #(
        .NREQ    (4),
        .DBITS   (8),
        .TIMEOUT (16)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req_valid),
        .i_req_data  (req_data),
        .i_req_last  (req_last),
        .o_req_ready (o_req_ready),
        .o_wr_uart   (o_wr_uart),
        .o_wr_data   (o_wr_data),
        .i_tx_full   (tx_full),
        .o_grant     (o_grant),
        .o_busy      (o_busy),
        .o_timeout   (o_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle, still well before the next edge
    task automatic settle();
        #2;
    endtask

    task automatic set_byte(input int k, input logic [7:0] b);
        req_data[k*8 +: 8] = b;
    endtask

    // Protocol monitor: no write while full; pending requesters hold data/last
    logic [3:0]  pend_q;
    logic [31:0] data_q;
    logic [3:0]  last_q;
    always @(negedge clk) begin
        if (!rst_n) begin
            pend_q = '0;
        end else begin
            if (tx_full) chk("no_wr_when_full", 32'(o_wr_uart), 32'd0);
            for (int k = 0; k < 4; k++) begin
                if (pend_q[k] && req_valid[k])
                    chk("hold_stable", {23'd0, req_last[k], req_data[k*8 +: 8]},
                        {23'd0, last_q[k], data_q[k*8 +: 8]});
            end
            pend_q = req_valid & ~o_req_ready;
            data_q = req_data;
            last_q = req_last;
        end
    end

    int exp_order[5] = '{0, 1, 2, 3, 0};

    initial begin
        pend_q    = '0;
        data_q    = '0;
        last_q    = '0;
        rst_n     = 1'b0;
        req_valid = 4'hF;
        req_data  = 32'hDEAD_BEEF;
        req_last  = 4'hF;
        tx_full   = 1'b0;

        // ---------------- reset state ----------------
        #3;
        chk("rst_grant", 32'(o_grant), 32'd0);
        chk("rst_ready", 32'(o_req_ready), 32'd0);
        chk("rst_wr", 32'(o_wr_uart), 32'd0);
        tick();
        tick();
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_wdata", 32'(o_wr_data), 32'd0);
        chk("rst_timeout", 32'(o_timeout), 32'd0);
        $display("reset: outputs held at zero");
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        rst_n     = 1'b1;

        // ---------------- 1: single requester ----------------
        req_valid[0] = 1'b1;
        set_byte(0, 8'hA1);
        settle();
        chk("t1_idle_grant", 32'(o_grant), 32'd0);
        chk("t1_idle_wr", 32'(o_wr_uart), 32'd0);
        tick();
        settle();
        chk("t1_grant", 32'(o_grant), 32'h1);
        chk("t1_busy", 32'(o_busy), 32'd1);
        chk("t1_ready", 32'(o_req_ready), 32'h1);
        chk("t1_wr_a1", 32'(o_wr_uart), 32'd1);
        chk("t1_data_a1", 32'(o_wr_data), 32'hA1);
        $display("t1: byte 0x%0h wr=%0b", o_wr_data, o_wr_uart);
        tick();
        set_byte(0, 8'hA2);
        settle();
        chk("t1_wr_a2", 32'(o_wr_uart), 32'd1);
        chk("t1_data_a2", 32'(o_wr_data), 32'hA2);
        $display("t1: byte 0x%0h wr=%0b", o_wr_data, o_wr_uart);
        tick();
        set_byte(0, 8'hA3);
        req_last[0] = 1'b1;
        settle();
        chk("t1_wr_a3", 32'(o_wr_uart), 32'd1);
        chk("t1_data_a3", 32'(o_wr_data), 32'hA3);
        chk("t1_grant_a3", 32'(o_grant), 32'h1);
        $display("t1: byte 0x%0h wr=%0b (last)", o_wr_data, o_wr_uart);
        tick();
        req_valid = '0;
        req_last  = '0;
        settle();
        chk("t1_done_busy", 32'(o_busy), 32'd0);
        chk("t1_done_grant", 32'(o_grant), 32'd0);
        chk("t1_done_wr", 32'(o_wr_uart), 32'd0);

        // ---------------- 2: round robin from reset ----------------
        rst_n = 1'b0;
        tick();
        rst_n     = 1'b1;
        req_valid = 4'hF;
        req_last  = 4'hF;
        req_data  = 32'h1312_1110;
        for (int p = 0; p < 5; p++) begin
            settle();
            chk("t2_idle_busy", 32'(o_busy), 32'd0);
            tick();
            settle();
            chk("t2_grant", 32'(o_grant), 32'(1 << exp_order[p]));
            chk("t2_data", 32'(o_wr_data), 32'(8'h10 + exp_order[p]));
            $display("t2: packet %0d grant=%b data=0x%0h", p, o_grant, o_wr_data);
            tick();
        end
        req_valid = '0;
        req_last  = '0;
        settle();
        chk("t2_done_busy", 32'(o_busy), 32'd0);

        // ---------------- 3: packet lock ----------------
        tick();
        req_valid[2] = 1'b1;
        set_byte(2, 8'h20);
        settle();
        chk("t3_idle_grant", 32'(o_grant), 32'd0);
        tick();
        req_valid[1] = 1'b1;
        req_last[1]  = 1'b1;
        set_byte(1, 8'h55);
        settle();
        chk("t3_grant_b0", 32'(o_grant), 32'h4);
        chk("t3_ready_b0", 32'(o_req_ready), 32'h4);
        chk("t3_data_b0", 32'(o_wr_data), 32'h20);
        $display("t3: req2 byte 0x%0h", o_wr_data);
        for (int b = 1; b < 4; b++) begin
            tick();
            set_byte(2, 8'(8'h20 + b));
            req_last[2] = (b == 3);
            settle();
            chk("t3_grant_bn", 32'(o_grant), 32'h4);
            chk("t3_wr_bn", 32'(o_wr_uart), 32'd1);
            chk("t3_data_bn", 32'(o_wr_data), 32'(8'h20 + b));
            $display("t3: req2 byte 0x%0h", o_wr_data);
        end
        tick();
        req_valid[2] = 1'b0;
        req_last[2]  = 1'b0;
        settle();
        chk("t3_gap_grant", 32'(o_grant), 32'd0);
        tick();
        settle();
        chk("t3_req1_grant", 32'(o_grant), 32'h2);
        chk("t3_req1_data", 32'(o_wr_data), 32'h55);
        $display("t3: req1 granted after packet, data 0x%0h", o_wr_data);
        tick();
        req_valid = '0;
        req_last  = '0;
        settle();
        chk("t3_done_busy", 32'(o_busy), 32'd0);

        // ---------------- 4: backpressure ----------------
        tick();
        req_valid[2] = 1'b1;
        set_byte(2, 8'h30);
        settle();
        chk("t4_idle_grant", 32'(o_grant), 32'd0);
        tick();
        settle();
        chk("t4_grant", 32'(o_grant), 32'h4);
        chk("t4_data_30", 32'(o_wr_data), 32'h30);
        tick();
        set_byte(2, 8'h31);
        tx_full = 1'b1;
        for (int s = 0; s < 5; s++) begin
            settle();
            chk("t4_stall_wr", 32'(o_wr_uart), 32'd0);
            chk("t4_stall_ready", 32'(o_req_ready), 32'd0);
            chk("t4_stall_grant", 32'(o_grant), 32'h4);
            $display("t4: stall cycle %0d wr=%0b", s, o_wr_uart);
            tick();
        end
        tx_full = 1'b0;
        settle();
        chk("t4_resume_wr", 32'(o_wr_uart), 32'd1);
        chk("t4_resume_data", 32'(o_wr_data), 32'h31);
        chk("t4_resume_ready", 32'(o_req_ready), 32'h4);
        tick();
        set_byte(2, 8'h32);
        req_last[2] = 1'b1;
        settle();
        chk("t4_next_data", 32'(o_wr_data), 32'h32);
        chk("t4_next_wr", 32'(o_wr_uart), 32'd1);
        tick();
        req_valid = '0;
        req_last  = '0;
        settle();
        chk("t4_done_wr", 32'(o_wr_uart), 32'd0);
        chk("t4_done_busy", 32'(o_busy), 32'd0);

        // ---------------- 6: reset mid-packet ----------------
        tick();
        req_valid[1] = 1'b1;
        set_byte(1, 8'h60);
        settle();
        chk("t6_idle_grant", 32'(o_grant), 32'd0);
        tick();
        settle();
        chk("t6_locked_grant", 32'(o_grant), 32'h2);
        chk("t6_locked_wr", 32'(o_wr_uart), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_grant", 32'(o_grant), 32'd0);
        chk("t6_rst_busy", 32'(o_busy), 32'd0);
        chk("t6_rst_wr", 32'(o_wr_uart), 32'd0);
        chk("t6_rst_ready", 32'(o_req_ready), 32'd0);
        chk("t6_rst_wdata", 32'(o_wr_data), 32'd0);
        $display("t6: reset mid-packet grant=%b", o_grant);
        tick();
        rst_n     = 1'b1;
        req_valid = 4'b1001;
        req_last  = 4'b1001;
        set_byte(0, 8'h61);
        set_byte(3, 8'h63);
        settle();
        chk("t6_after_idle", 32'(o_grant), 32'd0);
        tick();
        settle();
        chk("t6_restart_grant", 32'(o_grant), 32'h1);
        chk("t6_restart_data", 32'(o_wr_data), 32'h61);
        $display("t6: restart grant=%b", o_grant);
        tick();
        req_valid = '0;
        req_last  = '0;
        settle();
        chk("t6_done_busy", 32'(o_busy), 32'd0);

        // ---------------- 5: timeout ----------------
        tick();
        req_valid[0] = 1'b1;
        set_byte(0, 8'h40);
        settle();
        chk("t5_idle_grant", 32'(o_grant), 32'd0);
        tick();
        settle();
        chk("t5_grant0", 32'(o_grant), 32'h1);
        chk("t5_data40", 32'(o_wr_data), 32'h40);
        tick();
        req_valid    = 4'b1000;
        req_last[3]  = 1'b1;
        set_byte(3, 8'h77);
`ifdef UART_ARB_TIMEOUT_EN
        for (int k = 1; k < 16; k++) begin
            settle();
            chk("t5_no_pulse", 32'(o_timeout), 32'd0);
            chk("t5_held", 32'(o_grant), 32'h1);
            tick();
        end
        settle();
        chk("t5_pulse", 32'(o_timeout), 32'd1);
        chk("t5_pulse_grant", 32'(o_grant), 32'h1);
        $display("t5: timeout pulse 16 cycles after last transfer");
        tick();
        settle();
        chk("t5_after_pulse", 32'(o_timeout), 32'd0);
        chk("t5_released", 32'(o_grant), 32'd0);
        chk("t5_released_busy", 32'(o_busy), 32'd0);
        tick();
        settle();
        chk("t5_req3_grant", 32'(o_grant), 32'h8);
        chk("t5_req3_data", 32'(o_wr_data), 32'h77);
        chk("t5_req3_wr", 32'(o_wr_uart), 32'd1);
        $display("t5: req3 granted data 0x%0h", o_wr_data);
        tick();
        req_valid = '0;
        req_last  = '0;
`else
        for (int k = 1; k <= 40; k++) begin
            settle();
            chk("t5_no_pulse", 32'(o_timeout), 32'd0);
            chk("t5_held", 32'(o_grant), 32'h1);
            tick();
        end
        $display("t5: req0 still holds the port after 40 idle cycles");
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
